// File: rtl/vc_output_port.sv
// Egress stage: per-VC flit FIFOs, credit-gated round-robin VC arbitration onto one VC-tagged link.
// Lock FSM (PACKET_LOCK=1): IDLE = any eligible VC may win | LOCKED = only lock_vc_q may win until its tail.
module vc_output_port #(
  parameter int VC          = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int TYPE_WIDTH  = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int CREDITS     = 8,
  parameter int PACKET_LOCK = 0,
  parameter int VC_WIDTH    = (VC > 1) ? $clog2(VC) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [VC*DATA_WIDTH-1:0] data_in_bus,
  input  logic [VC-1:0]            valid_in_bus,
  output logic [VC-1:0]            ready_in_bus,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic [VC_WIDTH-1:0]      vc_out,
  output logic                     valid_out,
  input  logic [VC-1:0]            credit_in,
  output logic                     credit_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = $clog2(CREDITS + 1);

  typedef enum logic {S_IDLE, S_LOCKED} lock_state_t;

  logic [DATA_WIDTH-1:0] mem_q    [VC][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d    [VC][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q [VC];
  logic [PTR_W-1:0]      wr_ptr_d [VC];
  logic [PTR_W-1:0]      rd_ptr_q [VC];
  logic [PTR_W-1:0]      rd_ptr_d [VC];
  logic [CNT_W-1:0]      cnt_q    [VC];
  logic [CNT_W-1:0]      cnt_d    [VC];
  logic [CRD_W-1:0]      credit_q [VC];
  logic [CRD_W-1:0]      credit_d [VC];

  logic [VC_WIDTH-1:0]   last_grant_q, last_grant_d;
  lock_state_t           state_q, state_d;
  logic [VC_WIDTH-1:0]   lock_vc_q, lock_vc_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [VC_WIDTH-1:0]   vc_out_q, vc_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  credit_error_q, credit_error_d;

  logic [VC-1:0]         push, pop, eligible, ready;
  logic                  grant_valid;
  logic [VC_WIDTH-1:0]   grant_vc;
  logic [VC_WIDTH:0]     cand;
  logic [DATA_WIDTH-1:0] grant_flit;
  logic [1:0]            grant_type;

  assign grant_flit = mem_q[grant_vc][rd_ptr_q[grant_vc]];
  assign grant_type = grant_flit[DATA_WIDTH-TYPE_WIDTH +: 2];

  always_comb begin
    for (int v = 0; v < VC; v++) begin
      ready[v]    = (cnt_q[v] != CNT_W'(FIFO_DEPTH)) && !rst;
      push[v]     = valid_in_bus[v] && ready[v];
      eligible[v] = (cnt_q[v] != '0) && (credit_q[v] != '0) &&
                    ((PACKET_LOCK == 0) || (state_q == S_IDLE) ||
                     (lock_vc_q == VC_WIDTH'(v)));
    end
  end

  // Round-robin search beginning one past the previous winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_vc    = last_grant_q;
    cand        = '0;
    for (int i = 1; i <= VC; i++) begin
      cand = {1'b0, last_grant_q} + (VC_WIDTH+1)'(i);
      if (cand >= (VC_WIDTH+1)'(VC)) cand = cand - (VC_WIDTH+1)'(VC);
      if (!grant_valid && eligible[cand[VC_WIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_vc    = cand[VC_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    mem_d          = mem_q;
    credit_error_d = credit_error_q;
    for (int v = 0; v < VC; v++) begin
      pop[v]      = grant_valid && (grant_vc == VC_WIDTH'(v));
      wr_ptr_d[v] = wr_ptr_q[v];
      rd_ptr_d[v] = rd_ptr_q[v];
      cnt_d[v]    = cnt_q[v];
      credit_d[v] = credit_q[v];
      if (push[v]) begin
        mem_d[v][wr_ptr_q[v]] = data_in_bus[v*DATA_WIDTH +: DATA_WIDTH];
        wr_ptr_d[v]           = wr_ptr_q[v] + 1'b1;
      end
      if (pop[v]) rd_ptr_d[v] = rd_ptr_q[v] + 1'b1;
      if (push[v] && !pop[v]) cnt_d[v] = cnt_q[v] + 1'b1;
      if (pop[v] && !push[v]) cnt_d[v] = cnt_q[v] - 1'b1;
      // A send and a returned credit in the same cycle cancel out.
      if (pop[v] && !credit_in[v]) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (credit_in[v] && !pop[v]) begin
        if (credit_q[v] == CRD_W'(CREDITS)) credit_error_d = 1'b1;
        else                                credit_d[v]    = credit_q[v] + 1'b1;
      end
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    vc_out_d     = vc_out_q;
    valid_out_d  = grant_valid;
    last_grant_d = last_grant_q;
    state_d      = state_q;
    lock_vc_d    = lock_vc_q;
    if (grant_valid) begin
      data_out_d   = grant_flit;
      vc_out_d     = grant_vc;
      last_grant_d = grant_vc;
      if (PACKET_LOCK != 0) begin
        case (state_q)
          S_IDLE: begin
            if (grant_type == 2'b01) begin
              state_d   = S_LOCKED;
              lock_vc_d = grant_vc;
            end
          end
          S_LOCKED: if (grant_type == 2'b11) state_d = S_IDLE;
          default:  state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC; v++) begin
        wr_ptr_q[v] <= '0;
        rd_ptr_q[v] <= '0;
        cnt_q[v]    <= '0;
        credit_q[v] <= CRD_W'(CREDITS);
      end
      last_grant_q   <= VC_WIDTH'(VC - 1);
      state_q        <= S_IDLE;
      lock_vc_q      <= '0;
      data_out_q     <= '0;
      vc_out_q       <= '0;
      valid_out_q    <= 1'b0;
      credit_error_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      credit_q       <= credit_d;
      last_grant_q   <= last_grant_d;
      state_q        <= state_d;
      lock_vc_q      <= lock_vc_d;
      data_out_q     <= data_out_d;
      vc_out_q       <= vc_out_d;
      valid_out_q    <= valid_out_d;
      credit_error_q <= credit_error_d;
    end
  end

  // Flit storage needs no reset; occupancy is tracked by the counters.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign ready_in_bus = ready;
  assign data_out     = data_out_q;
  assign vc_out       = vc_out_q;
  assign valid_out    = valid_out_q;
  assign credit_error = credit_error_q;

endmodule
